// File: rtl/float16_pkg.sv
// ============================================================================
// float16_pkg : shared half-precision constants and sequencer states
// Revision    : 1.0
// ============================================================================
`default_nettype none

package float16_pkg;

    localparam int BIAS  = 15;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int ITER  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } state_e;

endpackage : float16_pkg

`default_nettype wire

// File: rtl/float_div.sv
// ============================================================================
// float_div : multi-cycle half-precision divider (restoring, truncating)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module float_div
    import float16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] floatA,
    input  logic [15:0] floatB,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient
);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [11:0]        rem_q, rem_d;
    logic [11:0]        quo_q, quo_d;
    logic [MAN_W:0]     fb_q, fb_d;
    logic signed [6:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic               a_zero_q, a_zero_d;
    logic               b_zero_q, b_zero_d;
    logic [15:0]        quotient_q, quotient_d;
    logic               done_q, done_d;

    logic               w_ge;
    logic [11:0]        w_sub;
    logic signed [6:0]  w_norm_exp;
    logic [MAN_W-1:0]   w_man;
    logic [15:0]        w_sat;

    // One compare-subtract step; the shift drops the always-zero MSB.
    assign w_ge       = (rem_q >= {1'b0, fb_q});
    assign w_sub      = w_ge ? (rem_q - {1'b0, fb_q}) : rem_q;
    assign w_norm_exp = quo_q[11] ? exp_q : (exp_q - 7'sd1);
    assign w_man      = quo_q[11] ? quo_q[10:1] : quo_q[9:0];
    assign w_sat      = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        fb_d       = fb_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        a_zero_d   = a_zero_q;
        b_zero_d   = b_zero_q;
        quotient_d = quotient_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d   = floatA[15] ^ floatB[15];
                    exp_d    = {2'b00, floatA[14:10]} - {2'b00, floatB[14:10]} + 7'(BIAS);
                    rem_d    = {1'b0, 1'b1, floatA[MAN_W-1:0]};
                    fb_d     = {1'b1, floatB[MAN_W-1:0]};
                    quo_d    = '0;
                    cnt_d    = '0;
                    a_zero_d = (floatA == 16'h0000);
                    b_zero_d = (floatB == 16'h0000);
                    state_d  = ((floatA == 16'h0000) || (floatB == 16'h0000)) ? NORM : DIV;
                end
            end
            DIV: begin
                rem_d = w_sub << 1;
                quo_d = {quo_q[10:0], w_ge};
                if (cnt_q == 4'(ITER - 1)) begin
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            NORM: begin
                if (a_zero_q) begin
                    quotient_d = 16'h0000;
                end else if (b_zero_q) begin
                    quotient_d = w_sat;
                end else if (w_norm_exp < 7'sd0) begin
                    quotient_d = 16'h0000;
                end else if (w_norm_exp > 7'sd30) begin
                    quotient_d = w_sat;
                end else begin
                    quotient_d = {sign_q, w_norm_exp[EXP_W-1:0], w_man};
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            fb_q       <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            a_zero_q   <= 1'b0;
            b_zero_q   <= 1'b0;
            quotient_q <= 16'h0000;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            fb_q       <= fb_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            a_zero_q   <= a_zero_d;
            b_zero_q   <= b_zero_d;
            quotient_q <= quotient_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign quotient = quotient_q;

endmodule : float_div

`default_nettype wire

// File: tb/tb_float_div.sv
// ============================================================================
// tb_float_div : directed vector table plus busy-start and mid-divide reset
// Revision     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_float_div;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] floatA;
    logic [15:0] floatB;
    logic        busy;
    logic        done;
    logic [15:0] quotient;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    float_div dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .floatA   (floatA),
        .floatB   (floatB),
        .busy     (busy),
        .done     (done),
        .quotient (quotient)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one divide; scrambles the inputs after accept so a late capture shows up.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output int lat);
        @(negedge clk);
        floatA = a;
        floatB = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        floatA = 16'hFFFF;
        floatB = 16'h1234;
        chk("busy_after_accept", int'(busy), 1);
        lat = 0;
        res = 16'h0000;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        if (!done) lat = -1;
        res = quotient;
    endtask

    initial begin
        logic [15:0] res;
        int          lat;
        int          ndone;
        int          first_lat;

        reset  = 1'b0;
        start  = 1'b0;
        floatA = 16'h0000;
        floatB = 16'h0000;

        vecs[0]  = '{16'h4200, 16'h3E00, 16'h4000, 13};
        vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, 13};
        vecs[2]  = '{16'hC600, 16'h4000, 16'hC200, 13};
        vecs[3]  = '{16'h0000, 16'h4000, 16'h0000, 1};
        vecs[4]  = '{16'h3C00, 16'h0000, 16'h7C00, 1};
        vecs[5]  = '{16'h0400, 16'h7800, 16'h0000, 13};
        vecs[6]  = '{16'h7800, 16'h0400, 16'h7C00, 13};
        vecs[7]  = '{16'h0400, 16'h3E00, 16'h0155, 13};
        vecs[8]  = '{16'hBC00, 16'h0000, 16'hFC00, 1};
        vecs[9]  = '{16'h0000, 16'h0000, 16'h0000, 1};
        vecs[10] = '{16'h7C00, 16'h4000, 16'h7800, 13};
        vecs[11] = '{16'h8000, 16'h3C00, 16'h8000, 13};
        vecs[12] = '{16'h3C00, 16'h3E00, 16'h3955, 13};
        vecs[13] = '{16'h7C00, 16'h3C00, 16'h7C00, 13};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_quotient", int'(quotient), 0);
        @(negedge clk);
        reset = 1'b1;

        // Consecutive calls start while done is still high: back-to-back accepts.
        for (int i = 0; i < 14; i++) begin
            run_div(vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_quotient", i), int'(res), int'(vecs[i].q));
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // start pulsed with new operands mid-divide must be ignored
        @(negedge clk);
        floatA = 16'h4200;
        floatB = 16'h3E00;
        start  = 1'b1;
        @(posedge clk);
        #1;
        ndone     = 0;
        first_lat = -1;
        res       = 16'h0000;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 5) begin
                start  = 1'b1;
                floatA = 16'h3C00;
                floatB = 16'h4200;
            end else begin
                start  = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first_lat = cyc;
                    res       = quotient;
                end
            end
        end
        chk("busy_start_done_count", ndone, 1);
        chk("busy_start_latency", first_lat, 13);
        chk("busy_start_quotient", int'(res), 16'h4000);
        chk("busy_start_idle_after", int'(busy), 0);

        // Reset during a divide aborts it silently
        @(negedge clk);
        floatA = 16'h4200;
        floatB = 16'h3E00;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quotient", int'(quotient), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_quotient_held", int'(quotient), 0);
        run_div(16'h4200, 16'h3E00, res, lat);
        chk("after_abort_quotient", int'(res), 16'h4000);
        chk("after_abort_latency", lat, 13);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_float_div

`default_nettype wire

// File: doc/float_div.md
FLOAT_DIV -- requirements
Module: float_div

Interface
REQ-001 SHALL have parameter none; the 16-bit format (1 sign, 5 exponent bias 15, 10 mantissa) is fixed.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request a divide; sampled only while busy=0.
REQ-005 SHALL have port: floatA  input  16  dividend; captured on the accept edge.
REQ-006 SHALL have port: floatB  input  16  divisor; captured on the accept edge.
REQ-007 SHALL have port: busy  output  1  high from the accept edge until the edge that raises done.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; quotient valid with it.
REQ-009 SHALL have port: quotient  output  16  result; held until the next done.

Function
REQ-010 SHALL implement states IDLE, DIV, NORM; the accept edge is a rising edge with start=1 and busy=0.
REQ-011 SHALL, on accept, register the operands, sign=A[15]^B[15], signed 7-bit exponent E=A[14:10]-B[14:10]+15, and fractions fa={1,A[9:0]}, fb={1,B[9:0]}.
REQ-012 SHALL treat a whole-word zero operand as special; A==0 gives quotient 0 (takes priority); otherwise B==0 gives {sign,5'h1F,10'h000}.
REQ-013 SHALL, for special cases, go IDLE->NORM on the accept edge T and raise done after edge T+1.
REQ-014 SHALL, for normal cases, go IDLE->DIV and run 12 restoring-division iterations over 12 edges: if R>=fb then bit=1 and R=R-fb, else bit=0; then R=R<<1, with R initialised to fa and at least 12 bits wide.
REQ-015 SHALL collect the bits MSB-first into q[11:0] and enter NORM after the 12th iteration edge (T+12).
REQ-016 SHALL, in NORM, normalise: if q[11]=1 then mantissa=q[10:1] and exponent E, else mantissa=q[9:0] and exponent E-1; truncate with no rounding.
REQ-017 SHALL flush to 16'h0000 (sign dropped) when the normalised exponent is <0; exponent field 0 is emitted as-is.
REQ-018 SHALL saturate to {sign,5'h1F,10'h000} when the normalised exponent is >30.
REQ-019 SHALL register quotient, pulse done, drop busy and return to IDLE on the NORM edge (T+13 for normal cases).
REQ-020 SHALL ignore start while busy=1; operand changes during busy SHALL NOT affect the result.
REQ-021 SHALL accept a new start in the cycle done is high (busy=0), allowing back-to-back operation.
REQ-022 SHALL apply no NaN or Inf interpretation to inputs; exponent 31 is treated arithmetically.

Reset
REQ-023 SHALL, while reset=0, force state IDLE, busy=0, done=0, quotient=16'h0000, and clear the iteration counter, R and q.
REQ-024 SHALL abort any operation in progress on reset assertion, with no done pulse, and accept a new start only after reset deasserts.

Structure
REQ-025 SHALL take the constants BIAS=15, EXP_W=5, MAN_W=10, ITER=12 and the state enum from shared package float16_pkg, which the multiplier and adder may also import.
REQ-026 SHALL be a single module; no sub-module is warranted, since the iteration datapath is one compare-subtract-shift.

Verification
REQ-027 SHALL verify 0x4200/0x3E00 (3.0/1.5) -> quotient 0x4000, with done exactly 13 cycles after the accept edge.
REQ-028 SHALL verify 0x3C00/0x4200 (1.0/3.0) -> 0x3555 (truncated), and 0xC600/0x4000 (-6/2) -> 0xC200.
REQ-029 SHALL verify 0x0000/0x4000 -> 0x0000, and 0x3C00/0x0000 -> 0x7C00, each with done 1 cycle after accept.
REQ-030 SHALL verify 0x0400/0x7800 (underflow) -> 0x0000, and 0x7800/0x0400 (overflow) -> 0x7C00.
REQ-031 SHALL verify that start pulsed with new operands at cycle 5 of a busy divide is ignored: one done pulse only, with the first result.
REQ-032 SHALL verify that reset asserted at cycle 6 of a divide gives no done and all outputs zero, and that a fresh 0x4200/0x3E00 afterwards yields 0x4000.
